// File: rtl/dcache_pkg.sv
// Shared types and helpers for the dual-lane data-memory responder.
// Load extraction is also used by the memory stage.
package dcache_pkg;

    localparam logic [2:0] MT_BS = 3'b000;
    localparam logic [2:0] MT_BU = 3'b001;
    localparam logic [2:0] MT_HS = 3'b010;
    localparam logic [2:0] MT_HU = 3'b011;
    localparam logic [2:0] MT_W  = 3'b100;

    localparam int WIDX_W = 30;

    typedef struct packed {
        logic [WIDX_W-1:0] widx;
        logic [3:0]        mask;
        logic [31:0]       data;
    } sb_entry_t;

    typedef struct packed {
        logic [3:0]  mask;
        logic [31:0] data;
    } st_lanes_t;

    function automatic logic is_byte(input logic [2:0] mt);
        return (mt == MT_BS) || (mt == MT_BU);
    endfunction

    function automatic logic is_half(input logic [2:0] mt);
        return (mt == MT_HS) || (mt == MT_HU);
    endfunction

    // Undefined encodings fall through to word behaviour.
    function automatic logic misaligned(input logic [2:0] mt, input logic [1:0] lo);
        if (is_byte(mt)) return 1'b0;
        if (is_half(mt)) return lo[0];
        return lo != 2'b00;
    endfunction

    function automatic st_lanes_t store_align(input logic [2:0] mt, input logic [1:0] lo,
                                              input logic [31:0] wdata);
        st_lanes_t r;
        if (is_byte(mt)) begin
            r.mask = 4'b0001 << lo;
            r.data = {4{wdata[7:0]}};
        end else if (is_half(mt)) begin
            r.mask = lo[1] ? 4'b1100 : 4'b0011;
            r.data = {2{wdata[15:0]}};
        end else begin
            r.mask = 4'b1111;
            r.data = wdata;
        end
        return r;
    endfunction

    function automatic logic [31:0] load_extract(input logic [2:0] mt, input logic [1:0] lo,
                                                 input logic [31:0] word);
        logic [31:0] sh;
        sh = word >> {lo, 3'b000};
        if (is_byte(mt)) return {{24{sh[7] & (mt == MT_BS)}}, sh[7:0]};
        if (is_half(mt)) return {{16{sh[15] & (mt == MT_HS)}}, sh[15:0]};
        return word;
    endfunction

endpackage

// File: rtl/dcache_store_buffer.sv
// In-order store FIFO: two-wide enqueue, one drain per cycle, and byte-wise
// forwarding lookup for two load queries (younger entries win).
module dcache_store_buffer
    import dcache_pkg::*;
#(
    parameter int SB_DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [1:0]               push,
    input  sb_entry_t [1:0]          push_entry,
    output logic                     can_accept,
    output logic                     empty,
    output logic                     drain_valid,
    output sb_entry_t                drain_entry,
    input  logic [1:0][WIDX_W-1:0]   query_widx,
    output logic [1:0][3:0]          hit_mask,
    output logic [1:0][31:0]         hit_data
);

    localparam int PW = $clog2(SB_DEPTH);
    localparam int CW = PW + 1;

    sb_entry_t        entries [SB_DEPTH];
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;
    logic [CW-1:0]    count;
    logic [PW-1:0]    idx;

    assign empty       = (count == '0);
    assign drain_valid = !empty;
    assign drain_entry = entries[head];
    assign can_accept  = (count <= CW'(SB_DEPTH - 2));

    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            tail  <= tail + PW'(push[0]) + PW'(push[1]);
            if (drain_valid) head <= head + 1'b1;
            count <= count + CW'(push[0]) + CW'(push[1]) - CW'(drain_valid);
        end
    end

    always_ff @(posedge clk) begin
        if (push[0]) entries[tail] <= push_entry[0];
        if (push[1]) entries[tail + PW'(push[0])] <= push_entry[1];
    end

    // Walk oldest to youngest so the youngest matching byte is left standing;
    // the entry draining this cycle is still part of the walk.
    always_comb begin
        hit_mask = '0;
        hit_data = '0;
        idx      = '0;
        for (int q = 0; q < 2; q++) begin
            for (int i = 0; i < SB_DEPTH; i++) begin
                idx = head + PW'(i);
                if ((CW'(i) < count) && (entries[idx].widx == query_widx[q])) begin
                    for (int b = 0; b < 4; b++) begin
                        if (entries[idx].mask[b]) begin
                            hit_mask[q][b]         = 1'b1;
                            hit_data[q][8*b +: 8]  = entries[idx].data[8*b +: 8];
                        end
                    end
                end
            end
        end
    end

endmodule

// File: rtl/dcache_responder.sv
// Dual-lane data-memory responder: word RAM behind an in-order store buffer,
// one-cycle registered load responses with byte-accurate store forwarding.
module dcache_responder
    import dcache_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int SB_DEPTH    = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic             req_ready,
    input  logic [1:0]       write_ena,
    input  logic [1:0]       read_ena,
    input  logic [1:0][2:0]  mem_type,
    input  logic [1:0][31:0] addr,
    input  logic [1:0][31:0] write_data,
    output logic [1:0]       resp_valid,
    output logic [1:0][31:0] read_data,
    output logic [1:0]       misalign,
    output logic             sb_empty
);

    localparam int AW = $clog2(DEPTH_WORDS);

    logic [31:0]             mem [DEPTH_WORDS];

    logic [1:0]              act, is_store, is_load, mis, push;
    logic [1:0][WIDX_W-1:0]  widx;
    sb_entry_t [1:0]         push_entry;
    st_lanes_t               al;
    logic [1:0][31:0]        ram_word, merged, rd_next;
    logic [1:0][3:0]         hit_mask;
    logic [1:0][31:0]        hit_data;
    logic                    drain_valid;
    sb_entry_t               drain_entry;
    logic                    unused_bits;

    assign unused_bits = ^{addr[0][31:AW+2], addr[1][31:AW+2], drain_entry.widx[WIDX_W-1:AW]};

    dcache_store_buffer #(.SB_DEPTH(SB_DEPTH)) u_sb (
        .clk         (clk),
        .rst         (rst),
        .push        (push),
        .push_entry  (push_entry),
        .can_accept  (req_ready),
        .empty       (sb_empty),
        .drain_valid (drain_valid),
        .drain_entry (drain_entry),
        .query_widx  (widx),
        .hit_mask    (hit_mask),
        .hit_data    (hit_data)
    );

    always_comb begin
        al = '0;
        for (int i = 0; i < 2; i++) begin
            act[i]      = req_valid[i] & req_ready;
            is_store[i] = write_ena[i];
            is_load[i]  = read_ena[i] & ~write_ena[i];
            mis[i]      = misaligned(mem_type[i], addr[i][1:0]);
            widx[i]     = WIDX_W'(addr[i][AW+1:2]);
            al          = store_align(mem_type[i], addr[i][1:0], write_data[i]);
            push[i]     = act[i] & is_store[i] & ~mis[i];
            push_entry[i].widx = widx[i];
            push_entry[i].mask = al.mask;
            push_entry[i].data = al.data;
            ram_word[i] = mem[addr[i][AW+1:2]];
            merged[i]   = ram_word[i];
            for (int b = 0; b < 4; b++) begin
                if (hit_mask[i][b]) merged[i][8*b +: 8] = hit_data[i][8*b +: 8];
            end
        end
        // An older lane-0 store in the same bundle overrides everything buffered.
        for (int b = 0; b < 4; b++) begin
            if (push[0] && (widx[0] == widx[1]) && push_entry[0].mask[b])
                merged[1][8*b +: 8] = push_entry[0].data[8*b +: 8];
        end
        for (int i = 0; i < 2; i++) begin
            rd_next[i] = load_extract(mem_type[i], addr[i][1:0], merged[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && drain_valid) begin
            for (int b = 0; b < 4; b++) begin
                if (drain_entry.mask[b])
                    mem[drain_entry.widx[AW-1:0]][8*b +: 8] <= drain_entry.data[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid <= '0;
            misalign   <= '0;
            read_data  <= '0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                resp_valid[i] <= act[i] & (is_load[i] | (is_store[i] & mis[i]));
                misalign[i]   <= act[i] & (is_load[i] | is_store[i]) & mis[i];
                read_data[i]  <= (act[i] & is_load[i] & ~mis[i]) ? rd_next[i] : 32'h0;
            end
        end
    end

endmodule

// File: tb/tb_dcache_responder.sv
// Bench for dcache_responder: byte-array memory reference where every store
// takes effect immediately in program order, so forwarding is implicit.
module tb_dcache_responder;
    import dcache_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic [1:0]       req_valid;
    logic             req_ready;
    logic [1:0]       write_ena;
    logic [1:0]       read_ena;
    logic [1:0][2:0]  mem_type;
    logic [1:0][31:0] addr;
    logic [1:0][31:0] write_data;
    logic [1:0]       resp_valid;
    logic [1:0][31:0] read_data;
    logic [1:0]       misalign;
    logic             sb_empty;

    dcache_responder #(.DEPTH_WORDS(1024), .SB_DEPTH(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .write_ena  (write_ena),
        .read_ena   (read_ena),
        .mem_type   (mem_type),
        .addr       (addr),
        .write_data (write_data),
        .resp_valid (resp_valid),
        .read_data  (read_data),
        .misalign   (misalign),
        .sb_empty   (sb_empty)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    logic [7:0]       ref_mem [4096];
    logic [1:0]       b_v, b_we, b_re;
    logic [1:0][2:0]  b_mt;
    logic [1:0][31:0] b_a, b_wd;
    logic [1:0]       e_v, e_mis;
    logic [1:0][31:0] e_d;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic clear_bundle();
        b_v = '0; b_we = '0; b_re = '0; b_mt = '0; b_a = '0; b_wd = '0;
    endtask

    task automatic lane(input int i, input logic we, input logic re, input logic [2:0] mt,
                        input logic [31:0] a, input logic [31:0] wd);
        b_v[i] = 1'b1; b_we[i] = we; b_re[i] = re; b_mt[i] = mt; b_a[i] = a; b_wd[i] = wd;
    endtask

    // Reference: size from type, misaligned when address is not a multiple of size.
    task automatic model_lane(input int i);
        int n;
        int ba;
        logic [31:0] val;
        logic is_signed;
        n = (b_mt[i] == 3'd0 || b_mt[i] == 3'd1) ? 1 : (b_mt[i] == 3'd2 || b_mt[i] == 3'd3) ? 2 : 4;
        is_signed = (b_mt[i] == 3'd0) || (b_mt[i] == 3'd2);
        ba = int'(b_a[i] & 32'hFFF);
        e_v[i] = 1'b0; e_mis[i] = 1'b0; e_d[i] = '0;
        if (!b_v[i]) return;
        if (!b_we[i] && !b_re[i]) return;
        if ((ba % n) != 0) begin
            e_v[i] = 1'b1; e_mis[i] = 1'b1;
            return;
        end
        if (b_we[i]) begin
            for (int k = 0; k < n; k++) ref_mem[ba + k] = b_wd[i][8*k +: 8];
        end else begin
            val = '0;
            for (int k = 0; k < n; k++) val = val | (32'(ref_mem[ba + k]) << (8 * k));
            if (n < 4 && is_signed && val[8*n-1]) val = val | (32'hFFFF_FFFF << (8 * n));
            e_v[i] = 1'b1; e_d[i] = val;
        end
    endtask

    task automatic send(input bit apply);
        req_valid = b_v; write_ena = b_we; read_ena = b_re;
        mem_type = b_mt; addr = b_a; write_data = b_wd;
        for (int n = 0; n < 20 && !req_ready; n++) begin
            @(posedge clk); #1;
            chk("stall_resp", 32'(resp_valid), 32'h0);
        end
        if (!req_ready) chk("ready_timeout", 32'(req_ready), 32'h1);
        e_v = '0; e_mis = '0; e_d = '0;
        if (apply) begin
            model_lane(0);
            model_lane(1);
        end
        @(posedge clk); #1;
        req_valid = '0;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("resp_valid%0d", i), 32'(resp_valid[i]), 32'(e_v[i]));
            if (e_v[i]) begin
                chk($sformatf("misalign%0d", i), 32'(misalign[i]), 32'(e_mis[i]));
                chk($sformatf("read_data%0d", i), read_data[i], e_d[i]);
            end
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk); #1;
            chk("idle_resp", 32'(resp_valid), 32'h0);
        end
    endtask

    task automatic wait_empty();
        for (int n = 0; n < 40 && !sb_empty; n++) begin
            @(posedge clk); #1;
        end
        chk("sb_empty", 32'(sb_empty), 32'h1);
    endtask

    function automatic logic [31:0] rand_addr();
        return ($urandom & 32'hFFFF_F000) | 32'h100 | (32'($urandom_range(0, 7)) << 2)
               | 32'($urandom_range(0, 3));
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        req_valid = '0; write_ena = '0; read_ena = '0;
        mem_type = '0; addr = '0; write_data = '0;
        for (int k = 0; k < 4096; k++) ref_mem[k] = 8'h00;
        clear_bundle();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'h0);
        chk("rst_misalign", 32'(misalign), 32'h0);
        chk("rst_read_data0", read_data[0], 32'h0);
        chk("rst_read_data1", read_data[1], 32'h0);
        chk("rst_sb_empty", 32'(sb_empty), 32'h1);
        chk("rst_req_ready", 32'(req_ready), 32'h1);
        rst = 1'b0;

        // RAM is not reset: zero it through the store path.
        for (int w = 0; w < 1024; w += 2) begin
            clear_bundle();
            lane(0, 1'b1, 1'b0, MT_W, 32'(w * 4), 32'h0);
            lane(1, 1'b1, 1'b0, MT_W, 32'((w + 1) * 4), 32'h0);
            send(1'b1);
        end
        wait_empty();

        // store then load, forwarded before drain
        clear_bundle(); lane(0, 1'b1, 1'b0, MT_W, 32'h100, 32'h1122_3344); send(1'b1);
        clear_bundle(); lane(0, 1'b0, 1'b1, MT_W, 32'h100, 32'h0); send(1'b1);
        chk("sw_lw_fwd", read_data[0], 32'h1122_3344);

        // same-bundle lane-0 store to lane-1 load
        clear_bundle();
        lane(0, 1'b1, 1'b0, MT_BU, 32'h203, 32'h0000_00AA);
        lane(1, 1'b0, 1'b1, MT_BU, 32'h203, 32'h0);
        send(1'b1);
        chk("lbu_fwd", read_data[1], 32'h0000_00AA);
        clear_bundle();
        lane(0, 1'b1, 1'b0, MT_BS, 32'h203, 32'h0000_00AA);
        lane(1, 1'b0, 1'b1, MT_BS, 32'h203, 32'h0);
        send(1'b1);
        chk("lb_fwd", read_data[1], 32'hFFFF_FFAA);

        // byte merge, buffered and drained
        clear_bundle(); lane(0, 1'b1, 1'b0, MT_HU, 32'h42, 32'h0000_BEEF); send(1'b1);
        clear_bundle(); lane(0, 1'b0, 1'b1, MT_W, 32'h40, 32'h0); send(1'b1);
        chk("merge_buf", read_data[0], 32'hBEEF_0000);
        wait_empty();
        clear_bundle(); lane(0, 1'b0, 1'b1, MT_W, 32'h40, 32'h0); send(1'b1);
        chk("merge_ram", read_data[0], 32'hBEEF_0000);

        // full buffer: two back-to-back store pairs from empty leave one slot free
        wait_empty();
        clear_bundle();
        lane(0, 1'b1, 1'b0, MT_W, 32'h180, 32'hC0C0_0001);
        lane(1, 1'b1, 1'b0, MT_W, 32'h184, 32'hC0C0_0002);
        send(1'b1);
        clear_bundle();
        lane(0, 1'b1, 1'b0, MT_W, 32'h188, 32'hC0C0_0003);
        lane(1, 1'b1, 1'b0, MT_W, 32'h18C, 32'hC0C0_0004);
        send(1'b1);
        chk("ready_full", 32'(req_ready), 32'h0);
        wait_empty();
        for (int w = 0; w < 4; w += 2) begin
            clear_bundle();
            lane(0, 1'b0, 1'b1, MT_W, 32'h180 + 32'(w * 4), 32'h0);
            lane(1, 1'b0, 1'b1, MT_W, 32'h184 + 32'(w * 4), 32'h0);
            send(1'b1);
        end
        chk("full_last", read_data[1], 32'hC0C0_0004);

        // misaligned load and store
        clear_bundle();
        lane(0, 1'b0, 1'b1, MT_W, 32'h102, 32'h0);
        lane(1, 1'b1, 1'b0, MT_HU, 32'h101, 32'h0000_5555);
        send(1'b1);
        chk("mis_both", 32'(misalign), 32'h3);
        chk("mis_data1", read_data[1], 32'h0);
        wait_empty();
        clear_bundle(); lane(0, 1'b0, 1'b1, MT_W, 32'h100, 32'h0); send(1'b1);
        chk("mis_ram", read_data[0], 32'h1122_3344);

        // randomized bundles over a small aliased window
        for (int t = 0; t < 400; t++) begin
            clear_bundle();
            for (int l = 0; l < 2; l++) begin
                if ($urandom_range(0, 3) != 0)
                    lane(l, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                         3'($urandom_range(0, 7)), rand_addr(), $urandom);
            end
            send(1'b1);
            if ($urandom_range(0, 4) == 0) idle(int'($urandom_range(1, 3)));
        end
        wait_empty();
        for (int w = 0; w < 8; w += 2) begin
            clear_bundle();
            lane(0, 1'b0, 1'b1, MT_W, 32'h100 + 32'(w * 4), 32'h0);
            lane(1, 1'b0, 1'b1, MT_W, 32'h104 + 32'(w * 4), 32'h0);
            send(1'b1);
        end

        // reset mid-drain: first entry drains, the remaining three are discarded
        wait_empty();
        clear_bundle();
        lane(0, 1'b1, 1'b0, MT_W, 32'h300, 32'hA1A1_A1A1);
        lane(1, 1'b1, 1'b0, MT_W, 32'h304, 32'hB2B2_B2B2);
        send(1'b0);
        clear_bundle();
        lane(0, 1'b1, 1'b0, MT_W, 32'h308, 32'hC3C3_C3C3);
        lane(1, 1'b1, 1'b0, MT_W, 32'h30C, 32'hD4D4_D4D4);
        send(1'b0);
        for (int k = 0; k < 4; k++) ref_mem[32'h300 + k] = 8'hA1;
        rst = 1'b1;
        req_valid = 2'b01; write_ena = '0; read_ena = 2'b01;
        mem_type = {MT_W, MT_W}; addr = {32'h0, 32'h100};
        @(posedge clk); #1;
        rst = 1'b0;
        req_valid = '0;
        chk("rstmid_resp_valid", 32'(resp_valid), 32'h0);
        chk("rstmid_sb_empty", 32'(sb_empty), 32'h1);
        chk("rstmid_req_ready", 32'(req_ready), 32'h1);
        idle(3);
        for (int w = 0; w < 4; w += 2) begin
            clear_bundle();
            lane(0, 1'b0, 1'b1, MT_W, 32'h300 + 32'(w * 4), 32'h0);
            lane(1, 1'b0, 1'b1, MT_W, 32'h304 + 32'(w * 4), 32'h0);
            send(1'b1);
        end
        chk("rstmid_discard", read_data[1], 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
